alu_dispatch: RTL and testbench

- Initiator side of the 4-bit-ctl MIPS ALU interface (ctl, a, b in; registered out, combinational zero back).
- Accepts an operation request over a valid/ready handshake and decodes aluop/funct to the ALU ctl encoding.
- Drives the ALU, waits out its one-cycle registered latency, and returns result, zero and error flags over a valid/ready response handshake.
- Sits between the execute-stage sequencer and the alu instance.

---
 rtl/alu_dispatch_if.sv | 28 ++
 rtl/alu_dispatch.sv | 159 +++++++++++++++
 tb/tb_alu_dispatch.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_dispatch_if.sv
// alu_dispatch_if: request/response handshake bundle between the execute-stage
// sequencer (master) and the ALU dispatcher (slave).
// Signals: req_valid/req_ready/req_aluop/req_funct/req_a/req_b, resp_valid/resp_ready/resp_result/resp_zero/resp_err.
interface alu_dispatch_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_aluop;
  logic [5:0]       req_funct;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;
  logic             resp_err;

  modport master (
    output req_valid, req_aluop, req_funct, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero, resp_err
  );

  modport slave (
    input  req_valid, req_aluop, req_funct, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero, resp_err
  );
endinterface

// File: rtl/alu_dispatch.sv
// alu_dispatch: decodes aluop/funct into the 4-bit ALU ctl code, issues one op to an
// external registered-output ALU and returns result/zero/err. Legal op: response 2 edges
// after acceptance; illegal funct or divide-by-zero: response right after acceptance.
// One op in flight; req_ready low until the response is taken (resp_ready).
// Ports: clk, rst_n (async active-low), bus (alu_dispatch_if.slave), alu_ctl/alu_a/alu_b
// to the ALU, alu_out/alu_zero back from it.
// Optional macro ALU_DISPATCH_OVF_TRAP_EN: signed add/sub (funct 0x20/0x22) overflow
// returns an error response instead of the wrapped result.
module alu_dispatch #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] ERR_RESULT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_dispatch_if.slave    bus,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;

  logic [3:0] dec_ctl;
  logic       dec_legal;
  logic       dec_div;
  logic       dec_err;

  // aluop/funct -> ALU ctl code
  always_comb begin
    dec_ctl   = 4'd0;
    dec_legal = 1'b1;
    dec_div   = 1'b0;
    case (bus.req_aluop)
      2'b00: dec_ctl = 4'd2;
      2'b01: dec_ctl = 4'd6;
      2'b11: dec_ctl = 4'd1;
      default: begin
        case (bus.req_funct)
          6'h20, 6'h21: dec_ctl = 4'd2;
          6'h22, 6'h23: dec_ctl = 4'd6;
          6'h24:        dec_ctl = 4'd0;
          6'h25:        dec_ctl = 4'd1;
          6'h26:        dec_ctl = 4'd13;
          6'h27:        dec_ctl = 4'd12;
          6'h2A:        dec_ctl = 4'd7;
          6'h18:        dec_ctl = 4'd10;
          6'h1A: begin
            dec_ctl = 4'd11;
            dec_div = 1'b1;
          end
          default:      dec_legal = 1'b0;
        endcase
      end
    endcase
  end

  // Errors known at acceptance bypass the ALU entirely.
  assign dec_err = !dec_legal || (dec_div && (bus.req_b == '0));

`ifdef ALU_DISPATCH_OVF_TRAP_EN
  logic             ovf_d;
  logic             ovf_q;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = bus.req_a + bus.req_b;
  assign diff = bus.req_a - bus.req_b;

  // Only the trapping signed forms; addu/subu and aluop 00/01 never trap.
  always_comb begin
    ovf_d = 1'b0;
    if (bus.req_aluop == 2'b10) begin
      if (bus.req_funct == 6'h20)
        ovf_d = (bus.req_a[WIDTH-1] == bus.req_b[WIDTH-1]) && (sum[WIDTH-1] != bus.req_a[WIDTH-1]);
      else if (bus.req_funct == 6'h22)
        ovf_d = (bus.req_a[WIDTH-1] != bus.req_b[WIDTH-1]) && (diff[WIDTH-1] != bus.req_a[WIDTH-1]);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_result <= '0;
      bus.resp_zero   <= 1'b0;
      bus.resp_err    <= 1'b0;
      alu_ctl         <= 4'd0;
      alu_a           <= '0;
      alu_b           <= '0;
`ifdef ALU_DISPATCH_OVF_TRAP_EN
      ovf_q           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            if (dec_err) begin
              bus.resp_result <= ERR_RESULT;
              bus.resp_zero   <= (ERR_RESULT == '0);
              bus.resp_err    <= 1'b1;
              bus.resp_valid  <= 1'b1;
              state           <= RESP;
            end else begin
              alu_ctl <= dec_ctl;
              alu_a   <= bus.req_a;
              alu_b   <= bus.req_b;
`ifdef ALU_DISPATCH_OVF_TRAP_EN
              ovf_q   <= ovf_d;
`endif
              state   <= EXEC;
            end
          end
        end
        // ALU registers its output at this edge; operands stay held.
        EXEC: state <= CAPT;
        CAPT: begin
`ifdef ALU_DISPATCH_OVF_TRAP_EN
          if (ovf_q) begin
            bus.resp_result <= ERR_RESULT;
            bus.resp_zero   <= (ERR_RESULT == '0);
            bus.resp_err    <= 1'b1;
          end else begin
            bus.resp_result <= alu_out;
            bus.resp_zero   <= alu_zero;
            bus.resp_err    <= 1'b0;
          end
`else
          bus.resp_result <= alu_out;
          bus.resp_zero   <= alu_zero;
          bus.resp_err    <= 1'b0;
`endif
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: directed scoreboard bench for alu_dispatch with a behavioural
// registered-output ALU attached to the alu_* ports.
module tb_alu_dispatch;
  localparam int          W          = 32;
  localparam logic [31:0] ERR_RESULT = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_dispatch_if #(.WIDTH(W)) bus ();

  logic [3:0]   alu_ctl;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_out;
  logic         alu_zero;

  alu_dispatch #(.WIDTH(W), .ERR_RESULT(ERR_RESULT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_ctl  (alu_ctl),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_out  (alu_out),
    .alu_zero (alu_zero)
  );

  // Behavioural ALU: registered out, combinational zero.
  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x + y;
      4'd6:  return x - y;
      4'd7:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd10: return 32'(x * y);
      4'd11: return (y == 32'd0) ? 32'd0 : 32'($signed(x) / $signed(y));
      4'd12: return ~(x | y);
      4'd13: return x ^ y;
      default: return 32'd0;
    endcase
  endfunction

  initial alu_out = '0;
  always @(posedge clk) alu_out <= alu_f(alu_ctl, alu_a, alu_b);
  assign alu_zero = (alu_out == '0);

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] aluop, input logic [5:0] funct,
                        input logic [31:0] a, input logic [31:0] b, input logic legal,
                        input logic [3:0] ctl, input logic [31:0] res, input logic zero,
                        input logic err, input int hold);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk({tag, ".req_ready_idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_aluop = aluop;
    bus.req_funct = funct;
    bus.req_a     = a;
    bus.req_b     = b;
    sb.push_back('{result: res, zero: zero, err: err});
    @(negedge clk);
    // Garbage on the request lines after acceptance must be ignored.
    bus.req_valid  = 1'b0;
    bus.req_aluop  = 2'($urandom);
    bus.req_funct  = 6'($urandom);
    bus.req_a      = $urandom;
    bus.req_b      = $urandom;
    bus.resp_ready = (hold == 0);
    chk({tag, ".req_ready_busy"}, 32'(bus.req_ready), 32'd0);
    if (legal) begin
      chk({tag, ".alu_ctl"}, 32'(alu_ctl), 32'(ctl));
      chk({tag, ".alu_a"}, alu_a, a);
      chk({tag, ".alu_b"}, alu_b, b);
    end
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), legal ? 32'd2 : 32'd0);
    e = sb.pop_front();
    chk({tag, ".result"}, bus.resp_result, e.result);
    chk({tag, ".zero"}, 32'(bus.resp_zero), 32'(e.zero));
    chk({tag, ".err"}, 32'(bus.resp_err), 32'(e.err));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, ".hold_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, ".hold_result"}, bus.resp_result, e.result);
        chk({tag, ".hold_req_ready"}, 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      chk({tag, ".release_valid"}, 32'(bus.resp_valid), 32'd0);
      chk({tag, ".release_req_ready"}, 32'(bus.req_ready), 32'd1);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, ".resp_result"}, bus.resp_result, 32'd0);
    chk({tag, ".resp_zero"}, 32'(bus.resp_zero), 32'd0);
    chk({tag, ".resp_err"}, 32'(bus.resp_err), 32'd0);
    chk({tag, ".alu_ctl"}, 32'(alu_ctl), 32'd0);
    chk({tag, ".alu_a"}, alu_a, 32'd0);
    chk({tag, ".alu_b"}, alu_b, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_aluop  = 2'b00;
    bus.req_funct  = 6'h00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    rst_n          = 1'b0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    //     tag         aluop  funct  a             b             legal ctl     result        zero  err  hold
    run_op("add",      2'b10, 6'h20, 32'd5,        32'd7,        1'b1, 4'd2,  32'd12,       1'b0, 1'b0, 0);
    run_op("beq_sub",  2'b01, 6'h00, 32'h1234,     32'h1234,     1'b1, 4'd6,  32'd0,        1'b1, 1'b0, 0);
    run_op("div0",     2'b10, 6'h1A, 32'd100,      32'd0,        1'b0, 4'd0,  ERR_RESULT,   ERR_RESULT == 0, 1'b1, 0);
    run_op("bad_fn",   2'b10, 6'h3F, 32'd1,        32'd2,        1'b0, 4'd0,  ERR_RESULT,   ERR_RESULT == 0, 1'b1, 0);
    run_op("slt_hold", 2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1,        1'b1, 4'd7,  32'd1,        1'b0, 1'b0, 5);
    run_op("lw_add",   2'b00, 6'h3F, 32'd10,       32'd20,       1'b1, 4'd2,  32'd30,       1'b0, 1'b0, 0);
    run_op("ori",      2'b11, 6'h00, 32'h100,      32'd1,        1'b1, 4'd1,  32'h101,      1'b0, 1'b0, 0);
    run_op("and",      2'b10, 6'h24, 32'hF0F0,     32'hFF00,     1'b1, 4'd0,  32'hF000,     1'b0, 1'b0, 0);
    run_op("or",       2'b10, 6'h25, 32'h0F,       32'hF0,       1'b1, 4'd1,  32'hFF,       1'b0, 1'b0, 0);
    run_op("xor",      2'b10, 6'h26, 32'hFF,       32'h0F,       1'b1, 4'd13, 32'hF0,       1'b0, 1'b0, 0);
    run_op("nor",      2'b10, 6'h27, 32'd0,        32'd0,        1'b1, 4'd12, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
    run_op("mul",      2'b10, 6'h18, 32'd6,        32'd7,        1'b1, 4'd10, 32'd42,       1'b0, 1'b0, 0);
    run_op("div",      2'b10, 6'h1A, 32'd100,      32'd7,        1'b1, 4'd11, 32'd14,       1'b0, 1'b0, 0);
    run_op("subu",     2'b10, 6'h23, 32'd5,        32'd7,        1'b1, 4'd6,  32'hFFFFFFFE, 1'b0, 1'b0, 0);
    run_op("addu_ovf", 2'b10, 6'h21, 32'h7FFFFFFF, 32'd1,        1'b1, 4'd2,  32'h80000000, 1'b0, 1'b0, 0);
`ifdef ALU_DISPATCH_OVF_TRAP_EN
    run_op("add_ovf",  2'b10, 6'h20, 32'h7FFFFFFF, 32'd1,        1'b1, 4'd2,  ERR_RESULT,   ERR_RESULT == 0, 1'b1, 0);
    run_op("sub_ovf",  2'b10, 6'h22, 32'h80000000, 32'd1,        1'b1, 4'd6,  ERR_RESULT,   ERR_RESULT == 0, 1'b1, 0);
`else
    run_op("add_wrap", 2'b10, 6'h20, 32'h7FFFFFFF, 32'd1,        1'b1, 4'd2,  32'h80000000, 1'b0, 1'b0, 0);
    run_op("sub_wrap", 2'b10, 6'h22, 32'h80000000, 32'd1,        1'b1, 4'd6,  32'h7FFFFFFF, 1'b0, 1'b0, 0);
`endif

    // Reset asserted while the op sits in CAPT: dropped, no response.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_aluop = 2'b10;
    bus.req_funct = 6'h20;
    bus.req_a     = 32'd3;
    bus.req_b     = 32'd4;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid_reset.no_resp", 32'(bus.resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    run_op("post_reset", 2'b10, 6'h22, 32'd9, 32'd4, 1'b1, 4'd6, 32'd5, 1'b0, 1'b0, 0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
